// File: rtl/lsu_mem_port.sv
// lsu_mem_port: in-order load/store queue driving a req/ack data-memory port.
// Define LSU_FWD_EN to enable store-to-load forwarding at push time.
module lsu_mem_port #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_addr,
  input  logic             in_is_st,
  input  logic [15:0]      in_wdata,
  input  logic [TAG_W-1:0] in_tag,
  output logic             mem_req,
  output logic             mem_we,
  output logic [15:0]      mem_addr,
  output logic [15:0]      mem_wdata,
  input  logic             mem_ack,
  input  logic [15:0]      mem_rdata,
  output logic             ld_valid,
  output logic [TAG_W-1:0] ld_tag,
  output logic [15:0]      ld_data
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  typedef enum logic {IDLE, REQ} state_t;
  state_t state, state_n;
  logic [15:0] q_addr [DEPTH];
  logic [15:0] q_wdata [DEPTH];
  logic [15:0] q_fdata [DEPTH];
  logic [TAG_W-1:0] q_tag [DEPTH];
  logic q_st [DEPTH];
  logic q_fwd [DEPTH];
  logic [PW-1:0] head, tail, nxt, idx;
  logic [CW-1:0] count, count_n;
  logic push, pop, issue, hit;
  logic [15:0] hit_data;
  assign push = in_valid & in_ready;
  assign nxt = head + 1'b1;
  assign count_n = count + CW'(push) - CW'(pop);
`ifdef LSU_FWD_EN
  // Later queue positions are younger, so the last match wins.
  always_comb begin
    hit = 1'b0;
    hit_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (CW'(i) < count && q_st[head + PW'(i)] && q_addr[head + PW'(i)] == in_addr) begin
        hit = 1'b1;
        hit_data = q_wdata[head + PW'(i)];
      end
    end
  end
`else
  assign hit = 1'b0;
  assign hit_data = '0;
`endif
  // A forwarded head is retired from IDLE without touching memory.
  always_comb begin
    state_n = state;
    pop = 1'b0;
    issue = 1'b0;
    idx = head;
    if (state == IDLE) begin
      if (count != '0) begin
        pop = q_fwd[head];
        issue = !q_fwd[head];
        state_n = q_fwd[head] ? IDLE : REQ;
      end
    end else if (mem_ack) begin
      pop = 1'b1;
      idx = nxt;
      issue = (count > CW'(1)) && !q_fwd[nxt];
      state_n = issue ? REQ : IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      head <= '0;
      tail <= '0;
      count <= '0;
      in_ready <= 1'b1;
      mem_req <= 1'b0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      ld_valid <= 1'b0;
      ld_tag <= '0;
      ld_data <= '0;
    end else begin
      state <= state_n;
      count <= count_n;
      in_ready <= count_n < CW'(DEPTH);
      if (push) tail <= tail + 1'b1;
      if (pop) head <= nxt;
      mem_req <= state_n == REQ;
      if (issue) begin
        mem_we <= q_st[idx];
        mem_addr <= q_addr[idx];
        mem_wdata <= q_wdata[idx];
      end
      ld_valid <= pop & !q_st[head];
      if (pop & !q_st[head]) begin
        ld_tag <= q_tag[head];
        ld_data <= state == IDLE ? q_fdata[head] : mem_rdata;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      q_addr[tail] <= in_addr;
      q_wdata[tail] <= in_wdata;
      q_tag[tail] <= in_tag;
      q_st[tail] <= in_is_st;
      q_fwd[tail] <= hit & !in_is_st;
      q_fdata[tail] <= hit_data;
    end
  end
endmodule

// File: tb/tb_lsu_mem_port.sv
// tb_lsu_mem_port: table-driven cycle vectors plus hand sequences for lsu_mem_port.
module tb_lsu_mem_port;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0, in_is_st = 1'b0, mem_ack = 1'b0;
  logic [15:0] in_addr = '0, in_wdata = '0, mem_rdata = '0;
  logic [5:0] in_tag = '0;
  logic in_ready, mem_req, mem_we, ld_valid;
  logic [15:0] mem_addr, mem_wdata, ld_data;
  logic [5:0] ld_tag;
  int checks = 0;
  int failures = 0;

  lsu_mem_port #(.DEPTH(4), .TAG_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_addr(in_addr), .in_is_st(in_is_st), .in_wdata(in_wdata), .in_tag(in_tag),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .ld_valid(ld_valid), .ld_tag(ld_tag),
    .ld_data(ld_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic v; logic [15:0] a; logic st; logic [15:0] wd; logic [5:0] tg;
    logic ack; logic [15:0] rd;
    logic rdy; logic req; logic we; logic [15:0] ma; logic [15:0] mwd;
    logic lv; logic [5:0] lt; logic [15:0] ld;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic v, input logic [15:0] a, input logic st,
      input logic [15:0] wd, input logic [5:0] tg, input logic ack, input logic [15:0] rd,
      input logic rdy, input logic req, input logic we, input logic [15:0] ma,
      input logic [15:0] mwd, input logic lv, input logic [5:0] lt, input logic [15:0] ld);
    vec_t r;
    r.v = v; r.a = a; r.st = st; r.wd = wd; r.tg = tg; r.ack = ack; r.rd = rd;
    r.rdy = rdy; r.req = req; r.we = we; r.ma = ma; r.mwd = mwd; r.lv = lv; r.lt = lt; r.ld = ld;
    return r;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [15:0] a, input logic st, input logic [15:0] wd,
      input logic [5:0] tg, input logic ack, input logic [15:0] rd);
    in_valid = v; in_addr = a; in_is_st = st; in_wdata = wd; in_tag = tg;
    mem_ack = ack; mem_rdata = rd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input vec_t t, input int n);
    drive(t.v, t.a, t.st, t.wd, t.tg, t.ack, t.rd);
    tick();
    chk($sformatf("v%0d.in_ready", n), 16'(in_ready), 16'(t.rdy));
    chk($sformatf("v%0d.mem_req", n), 16'(mem_req), 16'(t.req));
    chk($sformatf("v%0d.ld_valid", n), 16'(ld_valid), 16'(t.lv));
    if (t.req) begin
      chk($sformatf("v%0d.mem_addr", n), mem_addr, t.ma);
      chk($sformatf("v%0d.mem_we", n), 16'(mem_we), 16'(t.we));
      if (t.we) chk($sformatf("v%0d.mem_wdata", n), mem_wdata, t.mwd);
    end
    if (t.lv) begin
      chk($sformatf("v%0d.ld_tag", n), 16'(ld_tag), 16'(t.lt));
      chk($sformatf("v%0d.ld_data", n), ld_data, t.ld);
    end
  endtask

  initial begin
    // store held through three wait cycles, then a single load
    tbl.push_back(mk(1, 16'h0040, 1, 16'hBEEF, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 16'h0040, 16'hBEEF, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 16'h0012, 0, 0, 5, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 16'h0012, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 16'h1234, 1, 0, 0, 0, 0, 1, 5, 16'h1234));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    // fill to full with memory stalled, fifth push held until one ack frees a slot
    tbl.push_back(mk(1, 16'h0100, 1, 16'h0100, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 16'h0101, 1, 16'h0101, 0, 0, 0, 1, 1, 1, 16'h0100, 16'h0100, 0, 0, 0));
    tbl.push_back(mk(1, 16'h0102, 1, 16'h0102, 0, 0, 0, 1, 1, 1, 16'h0100, 16'h0100, 0, 0, 0));
    tbl.push_back(mk(1, 16'h0103, 1, 16'h0103, 0, 0, 0, 0, 1, 1, 16'h0100, 16'h0100, 0, 0, 0));
    tbl.push_back(mk(1, 16'h0104, 1, 16'h0104, 0, 0, 0, 0, 1, 1, 16'h0100, 16'h0100, 0, 0, 0));
    tbl.push_back(mk(1, 16'h0104, 1, 16'h0104, 0, 1, 0, 1, 1, 1, 16'h0101, 16'h0101, 0, 0, 0));
    tbl.push_back(mk(1, 16'h0104, 1, 16'h0104, 0, 0, 0, 0, 1, 1, 16'h0101, 16'h0101, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 1, 1, 1, 16'h0102, 16'h0102, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 1, 1, 1, 16'h0103, 16'h0103, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 1, 1, 1, 16'h0104, 16'h0104, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0));

    tick();
    tick();
    chk("rst.in_ready", 16'(in_ready), 16'h1);
    chk("rst.mem_req", 16'(mem_req), 16'h0);
    chk("rst.mem_we", 16'(mem_we), 16'h0);
    chk("rst.mem_addr", mem_addr, 16'h0);
    chk("rst.mem_wdata", mem_wdata, 16'h0);
    chk("rst.ld_valid", 16'(ld_valid), 16'h0);
    chk("rst.ld_tag", 16'(ld_tag), 16'h0);
    chk("rst.ld_data", ld_data, 16'h0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) step(tbl[i], i);

    // back-to-back loads with memory acking every cycle
    for (int i = 0; i < 4; i++) begin
      drive(1, 16'h0200 + 16'(i), 0, 0, 6'(10 + i), 0, 0);
      tick();
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("b2b.full", 16'(in_ready), 16'h0);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("b2b%0d.mem_req", k), 16'(mem_req), 16'h1);
      chk($sformatf("b2b%0d.mem_addr", k), mem_addr, 16'h0200 + 16'(k));
      drive(0, 0, 0, 0, 0, 1, 16'hA000 + 16'(k));
      tick();
      chk($sformatf("b2b%0d.ld_valid", k), 16'(ld_valid), 16'h1);
      chk($sformatf("b2b%0d.ld_tag", k), 16'(ld_tag), 16'(10 + k));
      chk($sformatf("b2b%0d.ld_data", k), ld_data, 16'hA000 + 16'(k));
    end
    chk("b2b.req_drop", 16'(mem_req), 16'h0);
    drive(0, 0, 0, 0, 0, 0, 0);
    tick();
    chk("b2b.ld_done", 16'(ld_valid), 16'h0);

    // reset mid-request with three entries queued
    for (int i = 0; i < 3; i++) begin
      drive(1, 16'h0300 + 16'(i), 0, 0, 6'(20 + i), 0, 0);
      tick();
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("mrst.req_before", 16'(mem_req), 16'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mrst.req_async", 16'(mem_req), 16'h0);
    chk("mrst.in_ready", 16'(in_ready), 16'h1);
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 0, 0, 0, 1, 16'h7777);
      tick();
      chk($sformatf("mrst%0d.ld_valid", i), 16'(ld_valid), 16'h0);
      chk($sformatf("mrst%0d.mem_req", i), 16'(mem_req), 16'h0);
    end
    drive(1, 16'h0310, 0, 0, 33, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    tick();
    chk("mrst.new_req", 16'(mem_req), 16'h1);
    chk("mrst.new_addr", mem_addr, 16'h0310);
    drive(0, 0, 0, 0, 0, 1, 16'h5555);
    tick();
    chk("mrst.new_lv", 16'(ld_valid), 16'h1);
    chk("mrst.new_tag", 16'(ld_tag), 16'd33);
    chk("mrst.new_data", ld_data, 16'h5555);
    chk("mrst.empty_req", 16'(mem_req), 16'h0);
    drive(0, 0, 0, 0, 0, 0, 0);
    tick();
    chk("mrst.empty_lv", 16'(ld_valid), 16'h0);
    chk("mrst.empty_req2", 16'(mem_req), 16'h0);

`ifdef LSU_FWD_EN
    // store then same-address load: only the store reaches memory
    drive(1, 16'h0020, 1, 16'hCAFE, 0, 0, 0);
    tick();
    drive(1, 16'h0020, 0, 0, 9, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("fwd%0d.req", i), 16'(mem_req), 16'h1);
      chk($sformatf("fwd%0d.we", i), 16'(mem_we), 16'h1);
      chk($sformatf("fwd%0d.addr", i), mem_addr, 16'h0020);
      tick();
    end
    drive(0, 0, 0, 0, 0, 1, 16'h0BAD);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("fwd.ack_req", 16'(mem_req), 16'h0);
    chk("fwd.ack_lv", 16'(ld_valid), 16'h0);
    tick();
    chk("fwd.lv", 16'(ld_valid), 16'h1);
    chk("fwd.tag", 16'(ld_tag), 16'd9);
    chk("fwd.data", ld_data, 16'hCAFE);
    chk("fwd.no_req", 16'(mem_req), 16'h0);
    tick();
    chk("fwd.lv_end", 16'(ld_valid), 16'h0);
    chk("fwd.no_req2", 16'(mem_req), 16'h0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
